// File: rtl/seq_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pkg
//  Purpose  : Shared types and constants for the 1101 scan controller slice.
//             - 3-bit state codes of the 1101 Moore detector (A..E)
//             - controller state type {IDLE, SHIFT, DRAIN, DONE}
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  localparam logic [2:0] ST_A = 3'b000;  // nothing matched
  localparam logic [2:0] ST_B = 3'b001;  // "1"
  localparam logic [2:0] ST_C = 3'b010;  // "11"
  localparam logic [2:0] ST_D = 3'b011;  // "110"
  localparam logic [2:0] ST_E = 3'b100;  // "1101" seen, z=1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_ctrl_if
//  Purpose  : Word handshake and status bundle of the scan controller.
//  Signals  : Start, Data           producer -> controller
//             Ready, Busy, Bit, Hit,
//             Done, Count           controller -> status/readback
//  Modports : master (producer side), slave (controller side)
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 16
) ();
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             Start;
  logic [WIDTH-1:0] Data;
  logic             Ready;
  logic             Busy;
  logic             Bit;
  logic             Hit;
  logic             Done;
  logic [CNT_W-1:0] Count;

  modport master (
    output Start, Data,
    input  Ready, Busy, Bit, Hit, Done, Count
  );

  modport slave (
    input  Start, Data,
    output Ready, Busy, Bit, Hit, Done, Count
  );
endinterface : seq_scan_ctrl_if
`default_nettype wire

// File: rtl/seq_scan_ctrl_det.sv
`default_nettype none
// ============================================================================
//  Module   : seq1101_det
//  Purpose  : Moore detector for the overlapping bit pattern 1101.
//             z is high while the machine sits in state E.
//  Ports    : Clock  in  rising-edge clock
//             Resetn in  asynchronous active-low reset (to state A)
//             Clr    in  synchronous clear to state A (wins over En)
//             En     in  advance the state on this edge
//             w      in  serial input bit
//             z      out detection flag (state == E)
//  Revision : 1.0 - initial release
// ============================================================================
module seq1101_det
  import seq_pkg::*;
(
  input  wire logic Clock,
  input  wire logic Resetn,
  input  wire logic Clr,
  input  wire logic En,
  input  wire logic w,
  output logic      z
);

  logic [2:0] r_state;
  logic [2:0] w_next;

  always_comb begin
    w_next = ST_A;
    case (r_state)
      ST_A:    w_next = w ? ST_B : ST_A;
      ST_B:    w_next = w ? ST_C : ST_A;
      ST_C:    w_next = w ? ST_C : ST_D;
      ST_D:    w_next = w ? ST_E : ST_A;
      // After a match the trailing "1" is reused, so a 1 lands in C (overlap).
      ST_E:    w_next = w ? ST_C : ST_A;
      default: w_next = ST_A;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_A;
    end else if (Clr) begin
      r_state <= ST_A;
    end else if (En) begin
      r_state <= w_next;
    end
  end

  assign z = (r_state == ST_E);

endmodule : seq1101_det
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_ctrl
//  Purpose  : Accepts a parallel word over Start/Ready, shifts it MSB-first
//             into a private 1101 detector, counts the detections of that
//             word and pulses Done when Count is final.
//  Ports    : Clock  in  rising-edge clock
//             Resetn in  asynchronous active-low reset
//             bus    seq_scan_ctrl_if.slave:
//                    Start/Data in, Ready/Busy/Bit/Hit/Done/Count out
//  Config   : SEQ_SCAN_CHAIN_EN - when defined, detector state carries
//             across words; otherwise the detector is cleared on every
//             accepting edge.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic       Clock,
  input  wire logic       Resetn,
  seq_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WIDTH - 1);

  ctrl_state_t      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_fed;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_en;
  logic w_clr;
  logic w_z;
  logic w_hit;

  // r_ready is high exactly in IDLE and DONE, so this is the accept condition.
  assign w_accept = bus.Start && r_ready;
  assign w_en     = (r_state == SHIFT);
  // z is only trusted after a fed bit; this masks a z left over from an
  // earlier word (chained mode) or sitting in E while idle.
  assign w_hit    = w_z && r_fed;

`ifdef SEQ_SCAN_CHAIN_EN
  assign w_clr = 1'b0;
`else
  assign w_clr = w_accept;
`endif

  seq1101_det u_det (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Clr    (w_clr),
    .En     (w_en),
    .w      (r_shreg[WIDTH-1]),
    .z      (w_z)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_fed   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_fed  <= w_en;
      r_done <= 1'b0;
      if (w_hit) begin
        r_count <= r_count + CNT_W'(1);
      end
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_shreg <= bus.Data;
            r_idx   <= '0;
            r_count <= '0;
            r_state <= SHIFT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        SHIFT: begin
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == c_LAST_IDX) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // One cycle lets z of the final bit reach Count before Done.
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ready = r_ready;
  assign bus.Busy  = r_busy;
  assign bus.Bit   = w_en & r_shreg[WIDTH-1];
  assign bus.Hit   = w_hit;
  assign bus.Done  = r_done;
  assign bus.Count = r_count;

endmodule : seq_scan_ctrl
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_scan_ctrl
//  Purpose  : Self-checking bench for seq_scan_ctrl. Expected detections
//             come from a bit-history model: a match ends wherever the last
//             four bits fed since the last clear read 1101.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int NCYC  = WIDTH + 2;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  seq_scan_ctrl_if #(.WIDTH(WIDTH)) bus ();

  seq_scan_ctrl #(.WIDTH(WIDTH)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Model history: last bits fed to the detector since its last clear.
  int m_hist = 0;
  int m_len  = 0;

`ifdef SEQ_SCAN_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept a word (Start driven now, before the next edge) and check every
  // cycle from 1 to WIDTH+2 against the model.
  task automatic scan_word(input logic [WIDTH-1:0] d, input bit noise,
                           input string nm, output int cnt, output longint t_done);
    bit exp_hit [0:NCYC];
    int run;
    bit exp_bit;
    t_done = -1;
    for (int i = 0; i <= NCYC; i++) exp_hit[i] = 1'b0;
    if (!CHAIN) m_len = 0;
    for (int p = 1; p <= WIDTH; p++) begin
      m_hist = ((m_hist << 1) | int'(d[WIDTH-p])) & 4'hF;
      m_len++;
      if (m_len >= 4 && m_hist == 4'b1101) exp_hit[p+1] = 1'b1;
    end
    bus.Start = 1'b1;
    bus.Data  = d;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    bus.Data  = WIDTH'($urandom);
    run = 0;
    for (int c = 1; c <= NCYC; c++) begin
      if (c > 1) begin @(posedge Clock); #1; end
      exp_bit = (c <= WIDTH) ? d[WIDTH-c] : 1'b0;
      total++;
      if (bus.Hit !== exp_hit[c])
        begin bad++; $display("FAIL %s hit c%0d: got %b want %b", nm, c, bus.Hit, exp_hit[c]); end
      total++;
      if (bus.Bit !== exp_bit)
        begin bad++; $display("FAIL %s bit c%0d: got %b want %b", nm, c, bus.Bit, exp_bit); end
      total++;
      if (bus.Done !== (c == NCYC))
        begin bad++; $display("FAIL %s done c%0d: got %b want %b", nm, c, bus.Done, (c == NCYC)); end
      total++;
      if (bus.Busy !== (c < NCYC))
        begin bad++; $display("FAIL %s busy c%0d: got %b want %b", nm, c, bus.Busy, (c < NCYC)); end
      total++;
      if (bus.Ready !== (c == NCYC))
        begin bad++; $display("FAIL %s ready c%0d: got %b want %b", nm, c, bus.Ready, (c == NCYC)); end
      total++;
      if (bus.Count !== CNT_W'(run))
        begin bad++; $display("FAIL %s count c%0d: got %0d want %0d", nm, c, bus.Count, run); end
      if (exp_hit[c]) run++;
      if (bus.Done === 1'b1) t_done = $time;
      if (noise && c < NCYC) begin
        bus.Start = 1'($urandom_range(0, 1));
        bus.Data  = WIDTH'($urandom);
      end else begin
        bus.Start = 1'b0;
      end
    end
    cnt = run;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge Clock); #1; end
  endtask

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.Data  = '0;
    Resetn    = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    total++; if (bus.Ready !== 1'b1) begin bad++; $display("FAIL reset ready: got %b want 1", bus.Ready); end
    total++; if (bus.Busy  !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.Busy); end
    total++; if (bus.Bit   !== 1'b0) begin bad++; $display("FAIL reset bit: got %b want 0", bus.Bit); end
    total++; if (bus.Hit   !== 1'b0) begin bad++; $display("FAIL reset hit: got %b want 0", bus.Hit); end
    total++; if (bus.Done  !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", bus.Done); end
    total++; if (bus.Count !== '0)   begin bad++; $display("FAIL reset count: got %0d want 0", bus.Count); end
    @(negedge Clock);
    Resetn = 1'b1;
    m_len  = 0;
    idle_cycles(2);
  endtask

  task automatic test_single();
    int c; longint t;
    scan_word(16'hD000, 1'b0, "d000", c, t);
    total++; if (c != 1) begin bad++; $display("FAIL d000 total: got %0d want 1", c); end
    idle_cycles(1);
  endtask

  task automatic test_overlap();
    int c; longint t;
    scan_word(16'hDB6D, 1'b0, "db6d", c, t);
    total++; if (bus.Count !== CNT_W'(5)) begin bad++; $display("FAIL db6d final: got %0d want 5", bus.Count); end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    int c1, c2; longint t1, t2;
    scan_word(16'h0000, 1'b0, "b2b0", c1, t1);
    scan_word(16'hFFFF, 1'b0, "b2b1", c2, t2);
    total++; if (c1 != 0 || c2 != 0) begin bad++; $display("FAIL b2b counts: got %0d,%0d want 0,0", c1, c2); end
    total++; if (t2 - t1 != 180) begin bad++; $display("FAIL b2b spacing: got %0d want 180", t2 - t1); end
    idle_cycles(1);
  endtask

  task automatic test_boundary();
    int c1, c2; longint t;
    scan_word(16'h0006, 1'b0, "bnd0", c1, t);
    idle_cycles(1);
    scan_word(16'h8000, 1'b0, "bnd1", c2, t);
    total++;
    if (c1 != 0 || c2 != int'(CHAIN))
      begin bad++; $display("FAIL boundary counts: got %0d,%0d want 0,%0d", c1, c2, int'(CHAIN)); end
    idle_cycles(1);
  endtask

  task automatic test_abort();
    int c; longint t; int seen;
    bus.Start = 1'b1;
    bus.Data  = 16'hDB6D;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    idle_cycles(6);      // now in SHIFT cycle 7
    #2;
    Resetn = 1'b0;
    #1;
    total++; if (bus.Ready !== 1'b1) begin bad++; $display("FAIL abort ready: got %b want 1", bus.Ready); end
    total++; if (bus.Busy  !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", bus.Busy); end
    total++; if (bus.Bit   !== 1'b0) begin bad++; $display("FAIL abort bit: got %b want 0", bus.Bit); end
    total++; if (bus.Hit   !== 1'b0) begin bad++; $display("FAIL abort hit: got %b want 0", bus.Hit); end
    total++; if (bus.Count !== '0)   begin bad++; $display("FAIL abort count: got %0d want 0", bus.Count); end
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    m_len  = 0;
    seen   = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge Clock); #1;
      if (bus.Done !== 1'b0 || bus.Ready !== 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort quiet: got %0d bad cycles want 0", seen); end
    scan_word(16'hD000, 1'b0, "postabort", c, t);
    total++; if (c != 1) begin bad++; $display("FAIL postabort total: got %0d want 1", c); end
    idle_cycles(1);
  endtask

  task automatic test_busy_start();
    int c; longint t;
    scan_word(16'hDB6D, 1'b1, "noise", c, t);
    total++; if (c != 5) begin bad++; $display("FAIL noise total: got %0d want 5", c); end
    idle_cycles(1);
  endtask

  task automatic test_random();
    int c; longint t;
    for (int k = 0; k < 30; k++) begin
      idle_cycles($urandom_range(0, 2));
      scan_word(WIDTH'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k), c, t);
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_back_to_back();
    test_boundary();
    test_abort();
    test_busy_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_scan_ctrl
`default_nettype wire

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scan controller for the 1101 Moore sequence detector. It accepts a parallel word over a valid/ready handshake and feeds it MSB-first, one bit per cycle, into a private detector instance. It counts the detections belonging to that word and reports the total with a one-cycle Done pulse. It sits between a word-producing producer and the status/readback logic, so the bit-serial detector can be used on parallel data.

## Interface
- WIDTH, 16, bits per scanned word (≥4)
- CNT_W, $clog2(WIDTH+1), width of Count (derived, not overridden)

- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous, active-low reset
- Start  in  1  word valid; accepted on a rising edge when Start && Ready
- Data  in  WIDTH  word to scan; sampled only on the accepting edge
- Ready  out  1  high in IDLE and DONE
- Busy  out  1  high in SHIFT and DRAIN
- Bit  out  1  bit currently presented to the detector (w); 0 outside SHIFT
- Hit  out  1  detector output z, qualified: z && fed
- Done  out  1  one-cycle pulse; Count is final
- Count  out  CNT_W  detections in the last scanned word; held until the next accept

## Operation
- Controller states: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - Start accepted → load shift register with Data, clear bit index and Count, go to SHIFT.
- SHIFT:
  - Bit = shreg[WIDTH-1]; detector En=1; shreg shifts left each cycle.
  - After WIDTH cycles → DRAIN.
- DRAIN:
  - En=0; one cycle to observe z produced by the last bit → DONE.
- DONE:
  - Done=1 for one cycle; Ready=1.
  - Start accepted → behaves as an IDLE accept (back-to-back).
  - Otherwise → IDLE.
- Detector sub-module: states A=000, B=001, C=010, D=011, E=100; z=(state==E).
  - Transitions with w=1: A→B, B→C, C→C, D→E, E→C.
  - Transitions with w=0: A→A, B→A, C→D, D→A, E→A.
  - State advances only when En=1. Clr (synchronous) forces A. Unused encodings go to A.
- fed: registered flag, 1 in the cycle after an En=1 cycle.
- Count increments by 1 in every cycle with z && fed.
- Overlap is counted: pattern period ≥3 bits, max WIDTH/3 matches, no saturation needed.
- Start while Busy is ignored; Data changes while Busy have no effect.

## Timing
- Accept edge = edge 0. SHIFT occupies cycles 1..WIDTH. DRAIN is cycle WIDTH+1. Done is high in cycle WIDTH+2.
- Start→Done latency: WIDTH+2 cycles. Minimum accept-to-accept interval: WIDTH+2 cycles, through the DONE accept.
- Hit is visible one cycle after the bit completing the pattern.
- Count is final when Done=1 and stays stable until the next accepting edge, where it becomes 0.
- Reset values:
  - Ready=1; Busy=0, Bit=0, Hit=0, Done=0, Count=0.
  - Detector state A; controller state IDLE; fed=0.
- Resetn asserted mid-scan aborts immediately to the reset values. No Done is produced for the aborted word.

## Configuration
- SEQ_SCAN_CHAIN_EN
  - Defined: detector state carries across words. A pattern spanning a word boundary is counted in the word holding its final bit. A z left over from the previous word is not recounted, because fed=0.
  - Undefined: Clr is pulsed on every accepting edge, so each word is scanned from state A.

## Structure
- Package seq_pkg holds:
  - detector state constants A..E (3-bit)
  - controller state typedef {IDLE, SHIFT, DRAIN, DONE}
- Sub-module seq1101_det has ports Clock, Resetn, Clr, En, w, z. It is a Moore machine with async reset to A.
- The controller, shift register, bit index counter and Count live in seq_scan_ctrl.

## Test plan
- Data=16'hD000 → Done at cycle 18 after the accept edge, Count=1, one Hit pulse in cycle 5.
- Data=16'hDB6D (overlapping matches) → Count=5; Hit pulses in cycles 5, 8, 11, 14 and 17.
- Data=16'h0000, then 16'hFFFF back-to-back via DONE accept → Count=0 then 0; second Done exactly 18 cycles after the first.
- Boundary-spanning pattern: 16'h0006 then 16'h8000.
  - SEQ_SCAN_CHAIN_EN defined → Counts 0, 1.
  - Undefined → Counts 0, 0.
- Resetn pulsed low in SHIFT cycle 7 of 16'hDB6D:
  - Outputs return to reset values asynchronously; no Done.
  - A following 16'hD000 scan gives Count=1.
- Start held high with changing Data during SHIFT → ignored, Count unaffected, Ready=0 throughout Busy.
